// File: rtl/tiny_intc.sv
// rtl/tiny_intc.sv - nested-priority interrupt controller with vectored single-request CPU handshake
// Lower channel index wins; an active handler masks itself and every higher index.

module tiny_intc #(
  parameter int                  CHANNELS      = 8,
  parameter int                  WIDTH         = 16,
  parameter int                  VECTOR_BASE   = 1,
  parameter int                  VECTOR_STRIDE = 2,
  parameter logic [CHANNELS-1:0] EDGE_MASK     = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_in,
  output logic                int_req,
  output logic [WIDTH-1:0]    int_vector,
  input  logic                int_ack,
  input  logic                int_done,
  input  logic [1:0]          reg_addr,
  input  logic                reg_wr,
  input  logic                reg_rd,
  input  logic [CHANNELS-1:0] reg_wdata,
  output logic [CHANNELS-1:0] reg_rdata
);

  localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
  localparam logic [1:0] ADDR_FORCE   = 2'd3;

  typedef enum logic {IDLE, REQUEST} state_t;

  state_t              state;
  logic [IDW-1:0]      req_id;
  logic [CHANNELS-1:0] sync1, sync2, sync2_q;
  logic [CHANNELS-1:0] enable, pending, active;

  logic [CHANNELS-1:0] rise, sw_clr, sw_force, ack_set, done_clr;
  logic [CHANNELS-1:0] pending_next, active_next;
  logic                ack_take, blocked, cand_found;
  logic [IDW-1:0]      cand_id;
  logic [WIDTH-1:0]    vec_calc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_q <= '0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync2_q <= sync2;
    end
  end

  assign rise     = sync2 & ~sync2_q;
  assign sw_clr   = (reg_wr && reg_addr == ADDR_PENDING) ? (reg_wdata & EDGE_MASK) : '0;
  assign sw_force = (reg_wr && reg_addr == ADDR_FORCE) ? reg_wdata : '0;
  assign ack_take = (state == REQUEST) && int_ack;

  // Priority scan: channels at or above the lowest active index are masked,
  // and that same lowest active bit is the one int_done retires.
  always_comb begin
    blocked    = 1'b0;
    cand_found = 1'b0;
    cand_id    = '0;
    done_clr   = '0;
    ack_set    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ack_set[i] = ack_take && (req_id == IDW'(i));
      if (active[i] && !blocked) begin
        blocked     = 1'b1;
        done_clr[i] = int_done;
      end
      if (!blocked && !cand_found && pending[i] && enable[i]) begin
        cand_found = 1'b1;
        cand_id    = IDW'(i);
      end
    end
  end

  // Hardware sets are OR-ed in last so they win over any clear in the same cycle.
  assign pending_next = (((pending & ~(sw_clr | (ack_set & EDGE_MASK))) | rise | sw_force) & EDGE_MASK)
                      | ((sync2 | sw_force) & ~EDGE_MASK);
  assign active_next  = (active & ~done_clr) | ack_set;
  assign vec_calc     = WIDTH'(VECTOR_BASE) + WIDTH'(cand_id) * WIDTH'(VECTOR_STRIDE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable  <= '0;
      pending <= '0;
      active  <= '0;
    end else begin
      if (reg_wr && reg_addr == ADDR_ENABLE) enable <= reg_wdata;
      pending <= pending_next;
      active  <= active_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_rdata <= '0;
    end else if (reg_rd) begin
      case (reg_addr)
        ADDR_ENABLE:  reg_rdata <= enable;
        ADDR_PENDING: reg_rdata <= pending;
        ADDR_ACTIVE:  reg_rdata <= active;
        default:      reg_rdata <= '0;
      endcase
    end
  end

  // The vector is frozen at request time; the CPU always sees what it will ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vector <= '0;
      req_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_found) begin
            state      <= REQUEST;
            int_req    <= 1'b1;
            int_vector <= vec_calc;
            req_id     <= cand_id;
          end
        end
        REQUEST: begin
          if (int_ack) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tiny_intc.md
TINY_INTC -- requirements
Module: tiny_intc

Interface
REQ-001 SHALL provide parameter CHANNELS, default 8, number of interrupt sources (legal range 1..16).
REQ-002 SHALL provide parameter WIDTH, default 16, CPU data/vector width.
REQ-003 SHALL provide parameter VECTOR_BASE, default 1, vector of channel 0.
REQ-004 SHALL provide parameter VECTOR_STRIDE, default 2, vector spacing between channels.
REQ-005 SHALL provide parameter EDGE_MASK, default 0, CHANNELS bits; bit=1 means edge-triggered, bit=0 means level-triggered.
REQ-006 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL provide port irq_in  input  CHANNELS  asynchronous interrupt sources.
REQ-009 SHALL provide port int_req  output  1  interrupt request to CPU.
REQ-010 SHALL provide port int_vector  output  WIDTH  start address of the requested handler.
REQ-011 SHALL provide port int_ack  input  1  one-cycle pulse; CPU has taken the request.
REQ-012 SHALL provide port int_done  input  1  one-cycle pulse; CPU executed reti.
REQ-013 SHALL provide port reg_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 ACTIVE, 3 FORCE.
REQ-014 SHALL provide ports reg_wr, reg_rd  input  1 each  register write/read strobes.
REQ-015 SHALL provide port reg_wdata  input  CHANNELS  write data.
REQ-016 SHALL provide port reg_rdata  output  CHANNELS  read data.

Function
REQ-017 SHALL synchronise each irq_in bit through two flops before any use.
REQ-018 SHALL set an edge channel's pending bit on a synchronised 0->1 transition; a level channel's pending bit SHALL equal its synchronised level each cycle.
REQ-019 SHALL form the candidate as the lowest-index channel with pending & ENABLE set and index strictly below the lowest set ACTIVE bit (all channels eligible when ACTIVE=0).
REQ-020 SHALL implement states IDLE and REQUEST; IDLE->REQUEST on the cycle a candidate exists; REQUEST->IDLE on int_ack.
REQ-021 SHALL drive int_req=1 exactly while in REQUEST.
REQ-022 SHALL latch int_vector = VECTOR_BASE + id*VECTOR_STRIDE, truncated to WIDTH bits, on IDLE->REQUEST; it SHALL stay stable until int_ack, even if a higher-priority source arrives or the candidate disappears (no withdrawal).
REQ-023 SHALL on int_ack set ACTIVE[id] of the latched channel and clear its pending bit if it is an edge channel.
REQ-024 SHALL on int_done clear the lowest-index set ACTIVE bit; int_done with ACTIVE=0 SHALL be ignored.
REQ-025 SHALL, when int_done and int_ack coincide, apply the done clear first, then the ack set.
REQ-026 SHALL stay in IDLE for at least one cycle after int_ack before the next request.
REQ-027 SHALL make latency 4 cycles: irq_in high before edge 1 gives int_req high after edge 4 (sync, sync, pending, state).
REQ-028 SHALL write ENABLE from reg_wdata; writing PENDING SHALL clear edge-channel pending bits where wdata=1; writing FORCE SHALL set pending bits where wdata=1; ACTIVE SHALL be read-only.
REQ-029 SHALL give hardware set priority over software clear when both hit the same pending bit in one cycle.
REQ-030 SHALL register reg_rdata with the selected register one cycle after reg_rd, holding its value otherwise.
REQ-031 SHALL ignore int_ack received in IDLE.

Reset
REQ-032 SHALL on reset clear sync flops, ENABLE, pending, ACTIVE, reg_rdata, set int_vector=0, int_req=0, state IDLE.
REQ-033 SHALL, on reset during REQUEST, drop int_req immediately (asynchronous) and discard the latched request.

Verification
REQ-034 Level: ENABLE=0x01, irq_in[0]=1 -> int_req=1 after edge 4, int_vector=0x0001; int_ack -> ACTIVE=0x01, int_req=0.
REQ-035 Nesting: ch3 active (ACTIVE=0x08), irq_in[1] edge, ENABLE=0xFF -> int_vector=0x0003; ack -> ACTIVE=0x0A; int_done -> ACTIVE=0x08.
REQ-036 Blocking: ACTIVE=0x02, irq_in[5] asserted -> no int_req until int_done, then int_req with vector 0x000B.
REQ-037 Stability: REQUEST for ch4 (vector 0x0009), ch0 rises before ack -> int_vector stays 0x0009; ch0 requested after the one-cycle IDLE gap.
REQ-038 Registers: EDGE_MASK=0xFF, FORCE write 0x20 -> PENDING reads 0x20 next cycle; PENDING write 0x20 with simultaneous ch5 edge -> bit stays 1.
REQ-039 Reset mid-REQUEST -> int_req=0 at once; ENABLE, ACTIVE, PENDING read 0x00 after release.
